// File: rtl/rev_counter_pkg.sv
// Shared constants for the reversible counter: count direction and limit behaviour.
package rev_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

endpackage : rev_counter_pkg

// File: rtl/rev_counter_nb.sv
// Reversible modulo-(MAX+1) counter with parallel load, wrap/saturate limit handling,
// carry-chain cascading and a sticky limit-event flag.
module rev_counter_nb
    import rev_counter_pkg::*;
#(
    parameter int unsigned     WIDTH = 16,
    parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SAT   = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             CI,
    input  logic             S,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] cnt,
    output logic             Rc,
    output logic             Co,
    output logic             ovf
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("rev_counter_nb: WIDTH must be within 2..32");
        end
        if (MAX == 64'd0 || MAX >= (64'd1 << WIDTH)) begin : g_bad_max
            $error("rev_counter_nb: MAX must be within 1..2**WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_W = MAX[WIDTH-1:0];

    // NOTE: declaration initialisers give the power-up value in simulation; the
    // synchronous reset below remains the functional way to clear state.
    logic [WIDTH-1:0] cnt_q = '0;
    logic             ovf_q = 1'b0;
    logic [WIDTH-1:0] cnt_d;
    logic             ovf_d;

    logic at_max;
    logic at_zero;
    logic step;

    assign at_max  = (cnt_q == MAX_W);
    assign at_zero = (cnt_q == '0);
    assign Rc      = (S == DIR_UP) ? at_max : at_zero;
    assign Co      = Rc & en & CI;
    assign step    = en & CI & ~load;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (load) begin
            cnt_d = (d > MAX_W) ? MAX_W : d;
            ovf_d = 1'b0;
        end else if (step) begin
            if (Rc) begin
                ovf_d = 1'b1;
                if (SAT == MODE_WRAP) begin
                    cnt_d = (S == DIR_DN) ? MAX_W : '0;
                end
            end else if (S == DIR_UP) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule : rev_counter_nb

// File: tb/tb_rev_counter_nb.sv
// Randomised and directed bench for rev_counter_nb: a wrap and a saturate instance
// (WIDTH=4, MAX=9) against an integer model, plus a two-stage 8-bit cascade.
module tb_rev_counter_nb;

    localparam int MAXV = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, en = 1'b0, ci = 1'b1, s = 1'b1, load = 1'b0;
    logic [3:0] d = '0;
    logic [3:0] cnt_w, cnt_s;
    logic       rc_w, co_w, ovf_w, rc_s, co_s, ovf_s;

    logic       c_rst = 1'b0, c_en = 1'b0, c_s = 1'b1;
    logic [3:0] lo_cnt, hi_cnt;
    logic       lo_rc, lo_co, lo_ovf, hi_rc, hi_co, hi_ovf;

    int checks = 0;
    int errors = 0;

    int m_cnt [2] = '{0, 0};
    bit m_ovf [2] = '{1'b0, 1'b0};
    int c_val = 0;

    rev_counter_nb #(.WIDTH(4), .MAX(9), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .CI(ci), .S(s), .load(load), .d(d),
        .cnt(cnt_w), .Rc(rc_w), .Co(co_w), .ovf(ovf_w)
    );

    rev_counter_nb #(.WIDTH(4), .MAX(9), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .CI(ci), .S(s), .load(load), .d(d),
        .cnt(cnt_s), .Rc(rc_s), .Co(co_s), .ovf(ovf_s)
    );

    rev_counter_nb #(.WIDTH(4)) u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .CI(1'b1), .S(c_s), .load(1'b0), .d(4'h0),
        .cnt(lo_cnt), .Rc(lo_rc), .Co(lo_co), .ovf(lo_ovf)
    );

    rev_counter_nb #(.WIDTH(4)) u_hi (
        .clk(clk), .rst(c_rst), .en(c_en), .CI(lo_co), .S(c_s), .load(1'b0), .d(4'h0),
        .cnt(hi_cnt), .Rc(hi_rc), .Co(hi_co), .ovf(hi_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference: counter value is an integer in 0..MAXV; wrap is modular arithmetic,
    // saturation is a clamp, and any step from the limit in the current direction is an event.
    function automatic void model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
            end else if (load) begin
                m_cnt[i] = (int'(d) > MAXV) ? MAXV : int'(d);
                m_ovf[i] = 1'b0;
            end else if (en && ci) begin
                if (s ? (m_cnt[i] == MAXV) : (m_cnt[i] == 0)) m_ovf[i] = 1'b1;
                if (i == 1)
                    m_cnt[i] = s ? ((m_cnt[i] + 1 > MAXV) ? MAXV : m_cnt[i] + 1)
                                 : ((m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1);
                else
                    m_cnt[i] = s ? (m_cnt[i] + 1) % (MAXV + 1)
                                 : (m_cnt[i] + MAXV) % (MAXV + 1);
            end
        end
        if (c_rst) c_val = 0;
        else if (c_en) c_val = c_s ? (c_val + 1) % 256 : (c_val + 255) % 256;
    endfunction

    task automatic tick();
        logic rc_exp [2];
        #1;
        for (int i = 0; i < 2; i++)
            rc_exp[i] = s ? (m_cnt[i] == MAXV) : (m_cnt[i] == 0);
        check("rc_wrap", {31'd0, rc_w}, {31'd0, rc_exp[0]});
        check("co_wrap", {31'd0, co_w}, {31'd0, rc_exp[0] & en & ci});
        check("rc_sat",  {31'd0, rc_s}, {31'd0, rc_exp[1]});
        check("co_sat",  {31'd0, co_s}, {31'd0, rc_exp[1] & en & ci});
        @(posedge clk);
        model_edge();
        #1;
        check("cnt_wrap", {28'd0, cnt_w}, m_cnt[0]);
        check("ovf_wrap", {31'd0, ovf_w}, {31'd0, m_ovf[0]});
        check("cnt_sat",  {28'd0, cnt_s}, m_cnt[1]);
        check("ovf_sat",  {31'd0, ovf_s}, {31'd0, m_ovf[1]});
        check("casc_val", {24'd0, hi_cnt, lo_cnt}, c_val);
    endtask

    initial begin
        #1;
        check("pwrup_cnt", {28'd0, cnt_w}, 32'd0);
        check("pwrup_ovf", {31'd0, ovf_w}, 32'd0);

        rst = 1'b1; c_rst = 1'b1;
        tick();
        rst = 1'b0; c_rst = 1'b0;

        // Wrap instance counts 1..9,0,1,2; event flag rises on the 9->0 step.
        s = 1'b1; en = 1'b1; ci = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("seq_up", {28'd0, cnt_w}, (k + 1) % 10);
            check("seq_ovf", {31'd0, ovf_w}, (k >= 9) ? 32'd1 : 32'd0);
        end

        // Saturating down from 1: stays at 0 with terminal flag held.
        load = 1'b1; d = 4'd1;
        tick();
        load = 1'b0; s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("sat_dn", {28'd0, cnt_s}, 32'd0);
            check("sat_rc", {31'd0, rc_s}, 32'd1);
            check("sat_ovf", {31'd0, ovf_s}, (k >= 1) ? 32'd1 : 32'd0);
        end

        // Load above MAX clamps, clears the flag, and beats an active enable.
        load = 1'b1; d = 4'd15; s = 1'b1; en = 1'b1;
        tick();
        check("clamp_cnt", {28'd0, cnt_w}, 32'd9);
        check("clamp_ovf", {31'd0, ovf_w}, 32'd0);

        // Reset overrides load and step; counting resumes afterwards.
        d = 4'd5;
        tick();
        rst = 1'b1; d = 4'd7;
        tick();
        check("rst_cnt", {28'd0, cnt_w}, 32'd0);
        check("rst_ovf", {31'd0, ovf_w}, 32'd0);
        rst = 1'b0; load = 1'b0;
        tick();
        check("resume", {28'd0, cnt_w}, 32'd1);

        // Enable without carry-in holds the count and blocks carry-out.
        ci = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_cnt", {28'd0, cnt_w}, 32'd1);
            check("hold_co", {31'd0, co_w}, 32'd0);
        end

        // Terminal flag follows direction combinationally at cnt=0.
        load = 1'b1; d = 4'd0; ci = 1'b1;
        tick();
        load = 1'b0; en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s = ~s;
            #1;
            check("rc_toggle", {31'd0, rc_w}, {31'd0, ~s});
            tick();
        end

        for (int k = 0; k < 400; k++) begin
            rst  = ($urandom % 32) == 0;
            load = ($urandom % 8) == 0;
            en   = ($urandom % 4) != 0;
            ci   = ($urandom % 5) != 0;
            s    = $urandom % 2;
            d    = 4'($urandom % 16);
            tick();
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;

        // Two 4-bit stages form one 8-bit counter: full up cycle then one down step.
        c_rst = 1'b1;
        tick();
        c_rst = 1'b0; c_en = 1'b1; c_s = 1'b1;
        for (int k = 0; k < 256; k++) tick();
        check("casc_wrap", {24'd0, hi_cnt, lo_cnt}, 32'h00);
        c_s = 1'b0;
        tick();
        check("casc_dn", {24'd0, hi_cnt, lo_cnt}, 32'hFF);
        c_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rev_counter_nb
